// File: rtl/four_bit_down_counter.sv
// four_bit_down_counter
// Loadable down counter used as a programmable countdown/interval timer.
// Software loads a start value; the counter decrements on each enabled clock
// and flags terminal count with a one-cycle borrow pulse.
// Optional feature macro: FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
//   undefined : one-shot, stops in EXPIRED after reaching 0
//   defined   : free-running, reloads the last loaded value after 0
module four_bit_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_borrow;
  logic             r_busy;
`ifdef FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  // Control FSM and counter datapath; load wins over everything but reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
`ifdef FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_borrow <= 1'b0;
      if (load) begin
        r_count  <= load_val;
`ifdef FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
        r_reload <= load_val;
`endif
        if (load_val != '0) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          RUN: begin
            r_busy <= 1'b1;
            if (in) begin
              if (r_count > ONE) begin
                r_count <= r_count - ONE;
              end else if (r_count == ONE) begin
                r_count  <= '0;
                r_borrow <= 1'b1;
`ifndef FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
                r_state  <= EXPIRED;
                r_busy   <= 1'b0;
`endif
              end else begin
`ifdef FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
                r_count <= r_reload;
`else
                r_count <= r_count;
`endif
              end
            end
          end
          EXPIRED: begin
            r_busy <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Terminal-count flag is decoded directly from the count register
  always_comb begin
    zero = (r_count == '0);
  end

  assign count  = r_count;
  assign borrow = r_borrow;
  assign busy   = r_busy;

endmodule

// File: tb/tb_four_bit_down_counter.sv
// tb_four_bit_down_counter
// Scoreboard bench: the driver applies stimulus at the falling edge and pushes
// the expected post-edge outputs from a behavioural model; a monitor pops and
// compares shortly after each rising edge.
module tb_four_bit_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         zero;
  logic         borrow;
  logic         busy;

  four_bit_down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .borrow   (borrow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit z;
    bit b;
    bit y;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model: a number counting down while "active"
  int m_count  = 0;
  int m_reload = 0;
  bit m_active = 0;
  bit m_borrow = 0;

  function automatic void push_exp();
    exp_t e;
    e.c = m_count;
    e.z = (m_count == 0);
    e.b = m_borrow;
    e.y = m_active;
    q.push_back(e);
  endfunction

  task automatic step(input bit ld, input int lv, input bit en);
    @(negedge clk);
    load     = ld;
    load_val = lv[W-1:0];
    in       = en;
    m_borrow = 0;
    if (ld) begin
      m_count  = lv % (1 << W);
      m_reload = m_count;
      m_active = (m_count != 0);
    end else if (m_active && en) begin
      if (m_count == 0) begin
        m_count = m_reload;
      end else begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_borrow = 1;
`ifndef FOUR_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
          m_active = 0;
`endif
        end
      end
    end
    push_exp();
  endtask

  task automatic check_now(input string name);
    n_vec++;
    if (count !== '0 || zero !== 1'b1 || busy !== 1'b0 || borrow !== 1'b0) begin
      n_err++;
      $display("FAIL %s: count=%0d zero=%b busy=%b borrow=%b, required count=0 zero=1 busy=0 borrow=0",
               name, count, zero, busy, borrow);
    end
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge
  task automatic mid_reset();
    @(negedge clk);
    load = 1'b0;
    in   = 1'b0;
    #2 reset = 1'b1;
    #1 check_now("async_reset");
    m_count  = 0;
    m_reload = 0;
    m_active = 0;
    m_borrow = 0;
    push_exp();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare DUT outputs after each rising edge against the queue
  initial begin
    exp_t e;
    logic [W-1:0] ec;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ec = e.c[W-1:0];
        n_vec++;
        if (count !== ec || zero !== e.z || borrow !== e.b || busy !== e.y) begin
          n_err++;
          $display("FAIL vec%0d @%0t: count=%0d zero=%b borrow=%b busy=%b, required count=%0d zero=%b borrow=%b busy=%b",
                   n_vec, $time, count, zero, borrow, busy, ec, e.z, e.b, e.y);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    #1 check_now("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset while counting from 5
    step(1, 5, 0);
    step(0, 0, 1);
    mid_reset();
    step(1, 6, 1);

    // One-shot countdown from 3
    step(1, 3, 0);
    repeat (5) step(0, 0, 1);

    // Enable gating
    step(1, 9, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Load coincides with the 1->0 step
    step(1, 2, 0);
    step(0, 0, 1);
    step(1, 12, 1);

    // Zero load
    step(1, 0, 1);
    repeat (3) step(0, 0, 1);

    // Free-running / expiry sequence from 2
    step(1, 2, 0);
    repeat (7) step(0, 0, 1);

    // Full-scale load
    step(1, (1 << W) - 1, 1);
    repeat (17) step(0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 9) == 0,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, (1 << W) - 1)),
             $urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    load = 1'b0;
    in   = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
